axi4_lite_write_slave_responder: RTL

AXI4_LITE_WRITE_SLAVE_RESPONDER -- requirements
Module: axi4_lite_write_slave_responder

---
 rtl/axi4_lite_write_slave_responder_pkg.sv | 34 +++
 rtl/axi4_lite_write_slave_responder_regbank.sv | 54 +++++
 rtl/axi4_lite_write_slave_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_write_slave_responder_pkg.sv
// Shared write-side package for the AXI4-Lite write master and slave.
// Holds the default bus widths, the write-response encoding, the write
// FSM state encoding and a saturating counter helper.
package axi4_lite_write_slave_responder_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } bresp_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GOT_AW = 2'b01,
        GOT_W  = 2'b10,
        RESP   = 2'b11
    } wr_state_e;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = 16'hFFFF;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi4_lite_write_slave_responder_regbank.sv
// Byte-strobed register bank for the AXI4-Lite write slave.
// One synchronous write port with per-byte strobes and one asynchronous
// read port. All words clear while rst is high; no write happens on a
// reset edge.
module axi4_lite_write_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int STRB_W     = DATA_WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Replace the strobed bytes of old_word with the matching bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                result[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                result[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return result;
    endfunction

    // Bank storage: clear on reset, byte-merge on write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[wr_index] <= merge_bytes(mem_r[wr_index], wr_data, wr_strb);
        end
    end

    assign rd_data = mem_r[rd_index];

endmodule

// File: rtl/axi4_lite_write_slave_responder.sv
// AXI4-Lite write-only slave with a small byte-strobed register bank.
// Accepts AW and W in either order or together, commits the write on the
// edge the second of the two arrives, then holds B until bready.
// Optional macro AXI4LITE_WRITE_SLAVE_ADDR_CHECK_EN enables DECERR for
// out-of-range and SLVERR for misaligned addresses; without it every
// write returns OKAY and the word index wraps modulo DEPTH.
module axi4_lite_write_slave_responder
    import axi4_lite_write_slave_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH    = AXI_DATA_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS = 32'h0000_0000,
    parameter int DEPTH         = 16,
    localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int STRB_W       = DATA_WIDTH / 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [STRB_W-1:0]        wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [IDX_W-1:0]         rd_index,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [15:0]              wr_count
);

    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam logic [ADDRESS_WIDTH:0]   BANK_BYTES = (ADDRESS_WIDTH+1)'(DEPTH * STRB_W);
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A    = ADDRESS_WIDTH'(DEPTH);

    wr_state_e                state_r;
    wr_state_e                next_s;
    logic [ADDRESS_WIDTH-1:0] awaddr_r;
    logic [DATA_WIDTH-1:0]    wdata_r;
    logic [STRB_W-1:0]        wstrb_r;
    bresp_e                   bresp_r;
    logic [15:0]              wr_count_r;

    logic                     awready_s;
    logic                     wready_s;
    logic                     aw_hs_s;
    logic                     w_hs_s;
    logic                     commit_s;
    logic                     we_s;
    logic [ADDRESS_WIDTH-1:0] cur_addr_s;
    logic [DATA_WIDTH-1:0]    cur_data_s;
    logic [STRB_W-1:0]        cur_strb_s;
    logic [ADDRESS_WIDTH-1:0] off_s;
    logic [ADDRESS_WIDTH-1:0] word_s;
    logic [IDX_W-1:0]         idx_s;
    bresp_e                   resp_s;
    logic                     unused_prot_s;

    // Channel readiness decoded from the state; both closed while in reset.
    always_comb begin
        awready_s = 1'b0;
        wready_s  = 1'b0;
        if (areset) begin
            awready_s = 1'b0;
            wready_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    awready_s = 1'b1;
                    wready_s  = 1'b1;
                end
                GOT_AW:  wready_s  = 1'b1;
                GOT_W:   awready_s = 1'b1;
                RESP:    awready_s = 1'b0;
                default: awready_s = 1'b0;
            endcase
        end
    end

    assign aw_hs_s = awvalid & awready_s;
    assign w_hs_s  = wvalid & wready_s;

    // Next-state logic; RESP is left only through the B handshake.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    next_s = RESP;
                end else if (aw_hs_s) begin
                    next_s = GOT_AW;
                end else if (w_hs_s) begin
                    next_s = GOT_W;
                end else begin
                    next_s = IDLE;
                end
            end
            GOT_AW: begin
                if (w_hs_s) begin
                    next_s = RESP;
                end else begin
                    next_s = GOT_AW;
                end
            end
            GOT_W: begin
                if (aw_hs_s) begin
                    next_s = RESP;
                end else begin
                    next_s = GOT_W;
                end
            end
            RESP: begin
                if (bready) begin
                    next_s = IDLE;
                end else begin
                    next_s = RESP;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // The commit edge may carry AW or W live, so bypass the holding registers.
    assign cur_addr_s = aw_hs_s ? awaddr : awaddr_r;
    assign cur_data_s = w_hs_s ? wdata : wdata_r;
    assign cur_strb_s = w_hs_s ? wstrb : wstrb_r;
    assign commit_s   = (state_r != RESP) && (next_s == RESP);

    // Address decode into a word index and the response code for this write.
    always_comb begin
        off_s  = cur_addr_s - MIN_ADDRESS;
        word_s = off_s >> ADDR_LSB;
        idx_s  = IDX_W'(word_s % DEPTH_A);
`ifdef AXI4LITE_WRITE_SLAVE_ADDR_CHECK_EN
        if ((cur_addr_s < MIN_ADDRESS) || ({1'b0, off_s} >= BANK_BYTES)) begin
            resp_s = DECERR;
        end else if (off_s[ADDR_LSB-1:0] != {ADDR_LSB{1'b0}}) begin
            resp_s = SLVERR;
        end else begin
            resp_s = OKAY;
        end
`else
        resp_s = OKAY;
`endif
    end

    assign we_s = commit_s && (resp_s == OKAY);

    // State, holding registers, latched response and the write counter.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= IDLE;
            awaddr_r   <= {ADDRESS_WIDTH{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            wstrb_r    <= {STRB_W{1'b0}};
            bresp_r    <= OKAY;
            wr_count_r <= 16'h0000;
        end else begin
            state_r <= next_s;
            if (aw_hs_s) begin
                awaddr_r <= awaddr;
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            if (commit_s) begin
                bresp_r <= resp_s;
            end
            if (we_s) begin
                wr_count_r <= sat_inc16(wr_count_r);
            end
        end
    end

    axi4_lite_write_regbank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .STRB_W     (STRB_W)
    ) u_regbank (
        .clk      (aclk),
        .rst      (areset),
        .we       (we_s),
        .wr_index (idx_s),
        .wr_data  (cur_data_s),
        .wr_strb  (cur_strb_s),
        .rd_index (rd_index),
        .rd_data  (rd_data)
    );

    // Protection attributes carry no meaning for this register bank.
    assign unused_prot_s = ^awprot;

    assign awready  = awready_s;
    assign wready   = wready_s;
    assign bvalid   = (state_r == RESP);
    assign bresp    = bresp_r;
    assign wr_count = wr_count_r;

endmodule
